auto_play_sequencer: RTL and testbench

//  Auto-play engine for the auto mode. Walks a song table one entry at a time and

---
 rtl/auto_play_sequencer.sv | 154 +++++++++++++++
 tb/tb_auto_play_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/auto_play_sequencer.sv
// Auto-play engine: walks a song table, timing each note and the gap after it.
// Drives the one-hot LED note vector and the buzzer code/octave pair.
module auto_play_sequencer #(
  parameter int BEAT_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 5_000_000,
  parameter int SONG_LEN    = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_active,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic       song_sel,
  output logic [6:0] auto_note_control,
  output logic [2:0] note_code,
  output logic [1:0] octave,
  output logic [4:0] index,
  output logic       playing,
  output logic       done
);
  localparam int NOTE_MAX = 8 * BEAT_CYCLES;
  localparam int MAXLOAD  = (NOTE_MAX > GAP_CYCLES) ? NOTE_MAX : GAP_CYCLES;
  // One extra count so a power-of-two maximum load still fits.
  localparam int TW = $clog2(MAXLOAD + 1);
  localparam logic [TW-1:0] BEAT = TW'(BEAT_CYCLES);
  localparam logic [TW-1:0] GAPL = TW'(GAP_CYCLES);
  localparam logic [4:0]    LAST = 5'(SONG_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_NOTE, S_GAP, S_DONE
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [4:0]    index_n;
  logic          song, song_n;
  logic [2:0]    code_n;
  logic [1:0]    oct_n;
  logic [7:0]    entry;
  logic [TW-1:0] load;
  logic [7:0]    hot;

  function automatic logic [7:0] rom(input logic sel,
                                     input logic [4:0] a);
    logic [7:0] d;
    d = '0;
    if (!sel) begin
      unique case (a)
        5'd0:    d = 8'h48;
        5'd1:    d = 8'h91;
        default: d = 8'h00;
      endcase
    end else begin
      // Full-length song with rests (code 0) and no end marker.
      d = {2'(a % 5'd3) + 2'd1, a[2:0], 3'(a % 5'd3)};
    end
    return d;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      timer     <= '0;
      index     <= '0;
      song      <= 1'b0;
      note_code <= '0;
      octave    <= '0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      index     <= index_n;
      song      <= song_n;
      note_code <= code_n;
      octave    <= oct_n;
    end
  end

  always_comb begin
    state_n = state;
    timer_n = timer;
    index_n = index;
    song_n  = song;
    code_n  = note_code;
    oct_n   = octave;
    entry   = rom(song, index);
    load    = (TW'(entry[2:0]) + TW'(1)) * BEAT;
    if (stop || !mode_active) begin
      state_n = S_IDLE;
      timer_n = '0;
      code_n  = '0;
      oct_n   = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state_n = S_FETCH;
            index_n = '0;
            song_n  = song_sel;
          end
        end
        S_FETCH: begin
          if (entry == 8'h00) begin
            state_n = S_DONE;
          end else begin
            state_n = S_NOTE;
            code_n  = entry[5:3];
            oct_n   = (entry[5:3] == 3'd0) ? 2'd0 : entry[7:6];
            timer_n = load;
          end
        end
        S_NOTE: begin
          if (!pause) begin
            if (timer == TW'(1)) begin
              state_n = S_GAP;
              code_n  = '0;
              oct_n   = '0;
              timer_n = GAPL;
            end else begin
              timer_n = timer - TW'(1);
            end
          end
        end
        S_GAP: begin
          if (!pause) begin
            if (timer == TW'(1)) begin
              timer_n = '0;
              if (index == LAST) begin
                state_n = S_DONE;
              end else begin
                index_n = index + 5'd1;
                state_n = S_FETCH;
              end
            end else begin
              timer_n = timer - TW'(1);
            end
          end
        end
        S_DONE:  state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Shift by code and drop bit 0 so code 0 maps to an all-zero vector.
  always_comb begin
    hot = 8'd1 << note_code;
    auto_note_control = hot[7:1];
  end

  assign playing = (state == S_FETCH) || (state == S_NOTE) ||
                   (state == S_GAP);
  assign done    = (state == S_DONE);
endmodule

// File: tb/tb_auto_play_sequencer.sv
// Bench for auto_play_sequencer: directed and random stimulus checked
// cycle by cycle against a queue-of-expected-frames song model.
module tb_auto_play_sequencer;
  localparam int BEAT = 4;
  localparam int GAPC = 2;
  localparam int LEN  = 32;

  localparam logic [2:0] PH_IDLE  = 3'd0;
  localparam logic [2:0] PH_FETCH = 3'd1;
  localparam logic [2:0] PH_NOTE  = 3'd2;
  localparam logic [2:0] PH_GAP   = 3'd3;
  localparam logic [2:0] PH_DONE  = 3'd4;

  typedef struct packed {
    logic [2:0] ph;
    logic [2:0] code;
    logic [1:0] oct;
    logic [4:0] idx;
  } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mode_active = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic pause = 1'b0;
  logic song_sel = 1'b0;
  logic [6:0] auto_note_control;
  logic [2:0] note_code;
  logic [1:0] octave;
  logic [4:0] index;
  logic playing;
  logic done;

  int nchk = 0;
  int nfail = 0;
  int cyc = 0;
  int done_cnt = 0;
  frame_t cur;
  frame_t q[$];

  auto_play_sequencer #(
    .BEAT_CYCLES(BEAT),
    .GAP_CYCLES(GAPC),
    .SONG_LEN(LEN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mode_active(mode_active),
    .start(start),
    .stop(stop),
    .pause(pause),
    .song_sel(song_sel),
    .auto_note_control(auto_note_control),
    .note_code(note_code),
    .octave(octave),
    .index(index),
    .playing(playing),
    .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] song_rom(input logic sel, input int i);
    logic [7:0] s0 [3];
    logic [1:0] o;
    logic [2:0] c;
    logic [2:0] d;
    s0 = '{8'h48, 8'h91, 8'h00};
    if (!sel) return (i < 3) ? s0[i] : 8'h00;
    o = 2'(i % 3 + 1);
    c = 3'(i % 8);
    d = 3'(i % 3);
    return {o, c, d};
  endfunction

  function automatic frame_t mk(input logic [2:0] ph, input logic [2:0] c,
                                input logic [1:0] o, input logic [4:0] i);
    frame_t f;
    f.ph = ph;
    f.code = c;
    f.oct = o;
    f.idx = i;
    return f;
  endfunction

  function automatic int note_len(input logic [7:0] e);
    return (int'(e[2:0]) + 1) * BEAT;
  endfunction

  // Expand a whole song into the frames seen after each clock edge.
  task automatic build(input logic sel);
    q.delete();
    for (int i = 0; i < LEN; i++) begin
      logic [7:0] e;
      logic [2:0] c;
      logic [1:0] o;
      e = song_rom(sel, i);
      q.push_back(mk(PH_FETCH, 3'd0, 2'd0, 5'(i)));
      if (e == 8'h00) begin
        q.push_back(mk(PH_DONE, 3'd0, 2'd0, 5'(i)));
        return;
      end
      c = e[5:3];
      o = (c == 3'd0) ? 2'd0 : e[7:6];
      repeat (note_len(e)) q.push_back(mk(PH_NOTE, c, o, 5'(i)));
      repeat (GAPC) q.push_back(mk(PH_GAP, 3'd0, 2'd0, 5'(i)));
    end
    q.push_back(mk(PH_DONE, 3'd0, 2'd0, 5'(LEN - 1)));
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    nchk++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    logic [18:0] got;
    logic [18:0] exp;
    logic [6:0] ea;
    logic pl;
    @(posedge clk);
    if (rst) begin
      cur = mk(PH_IDLE, 3'd0, 2'd0, 5'd0);
      q.delete();
    end else if (stop || !mode_active) begin
      cur = mk(PH_IDLE, 3'd0, 2'd0, cur.idx);
      q.delete();
    end else if (cur.ph == PH_IDLE) begin
      if (start) begin
        build(song_sel);
        cur = q.pop_front();
      end
    end else if (pause && (cur.ph == PH_NOTE || cur.ph == PH_GAP)) begin
      cur = cur;
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end else begin
      cur = mk(PH_IDLE, 3'd0, 2'd0, cur.idx);
    end
    cyc++;
    #1;
    if (done === 1'b1) done_cnt++;
    ea = (cur.code == 3'd0) ? 7'd0 : 7'(8'd1 << (cur.code - 3'd1));
    pl = (cur.ph == PH_FETCH) || (cur.ph == PH_NOTE) || (cur.ph == PH_GAP);
    got = {auto_note_control, note_code, octave, index, playing, done};
    exp = {ea, cur.code, cur.oct, cur.idx, pl, cur.ph == PH_DONE};
    nchk++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL cycle%0d {anc,code,oct,idx,play,done}: observed %0h expected %0h",
             cyc, got, exp);
    end
  endtask

  // Returns start-cycle-to-done-cycle count inclusive, or -1 on timeout.
  task automatic wait_done(input int s, input int budget, output int n);
    n = -1;
    for (int k = 0; k < budget; k++) begin
      step();
      if (done === 1'b1) begin
        n = cyc - s + 1;
        return;
      end
    end
  endtask

  task automatic wait_phase(input logic [2:0] ph, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (cur.ph == ph) return;
      step();
    end
    chk("wait_phase_timeout", int'(cur.ph), int'(ph));
  endtask

  initial begin
    int n;
    int s;
    int d0;
    int exp_len;
    cur = mk(PH_IDLE, 3'd0, 2'd0, 5'd0);

    rst = 1'b1;
    repeat (3) step();
    chk("rst_playing", int'(playing), 0);
    chk("rst_anc", int'(auto_note_control), 0);
    rst = 1'b0;
    mode_active = 1'b1;
    step();

    song_sel = 1'b0;
    start = 1'b1;
    s = cyc;
    step();
    start = 1'b0;
    step();
    chk("latency_code", int'(note_code), 1);
    chk("latency_oct", int'(octave), 1);
    chk("latency_anc", int'(auto_note_control), 1);
    wait_done(s, 100, n);
    chk("song0_total", n, 21);
    chk("song0_done_idx", int'(index), 2);
    step();
    chk("after_done_play", int'(playing), 0);

    start = 1'b1;
    s = cyc;
    step();
    start = 1'b0;
    repeat (2) step();
    pause = 1'b1;
    repeat (10) step();
    chk("pause_hold_code", int'(note_code), 1);
    pause = 1'b0;
    wait_done(s, 200, n);
    chk("pause_total", n, 31);
    step();

    d0 = done_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_phase(PH_GAP, 50);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_play", int'(playing), 0);
    chk("stop_code", int'(note_code), 0);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_idx", int'(index), 0);
    chk("restart_play", int'(playing), 1);
    wait_phase(PH_NOTE, 10);
    mode_active = 1'b0;
    step();
    mode_active = 1'b1;
    chk("mode_drop_play", int'(playing), 0);
    chk("mode_drop_code", int'(note_code), 0);
    step();
    chk("abort_no_done", done_cnt - d0, 0);

    song_sel = 1'b0;
    start = 1'b1;
    s = cyc;
    step();
    start = 1'b0;
    repeat (3) step();
    start = 1'b1;
    song_sel = 1'b1;
    step();
    start = 1'b0;
    chk("restart_ignored_idx", int'(index), 0);
    chk("restart_ignored_code", int'(note_code), 1);
    wait_done(s, 100, n);
    chk("sel_toggle_total", n, 21);
    chk("sel_toggle_idx", int'(index), 2);
    step();

    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    chk("start_stop_play", int'(playing), 0);
    step();

    exp_len = 2;
    for (int i = 0; i < LEN; i++)
      exp_len += 1 + note_len(song_rom(1'b1, i)) + GAPC;
    song_sel = 1'b1;
    start = 1'b1;
    s = cyc;
    step();
    start = 1'b0;
    song_sel = 1'b0;
    wait_done(s, 2000, n);
    chk("song1_total", n, exp_len);
    chk("song1_terminal_idx", int'(index), LEN - 1);
    step();

    for (int k = 0; k < 1500; k++) begin
      start = ($urandom_range(0, 9) == 0);
      stop = ($urandom_range(0, 99) == 0);
      pause = ($urandom_range(0, 4) == 0);
      mode_active = ($urandom_range(0, 149) != 0);
      song_sel = 1'($urandom_range(0, 1));
      step();
    end
    start = 1'b0;
    stop = 1'b0;
    pause = 1'b0;
    mode_active = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end
endmodule
